// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Requests one instruction word at a time from instruction memory, holds it
// for the decoder until it is accepted, then advances the program counter
// on an increment pulse or a taken branch.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch that waits
// TIMEOUT_CYCLES cycles without mem_ack. The FSM then parks in ERROR with a
// sticky fetch_error until reset.
module fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        increment_ins_count,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instruction,
    output logic        ins_valid,
    input  logic        ins_accept,
    output logic [15:0] pc,
    output logic        fetch_error
);

    typedef enum logic [2:0] {
        START,
        FETCH,
        READY,
        IDLE,
        ERROR
    } state_t;

    // Last counter value before the limit is reached; reaching it on a
    // further ackless FETCH cycle means TIMEOUT_CYCLES cycles have elapsed.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t state;
    logic   pending;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] timeout_count;
`else
    wire unused_timeout_cfg = ^TIMEOUT_LAST;
    assign fetch_error = 1'b0;
`endif

    // The read address is always the program counter.
    assign mem_addr = pc;

    // Fetch sequencing: state, pc, captured instruction, deferred increment
    // and the registered memory request all advance together here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= START;
            pc          <= RESET_PC;
            instruction <= 16'h0000;
            ins_valid   <= 1'b0;
            mem_req     <= 1'b0;
            pending     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            fetch_error   <= 1'b0;
            timeout_count <= 8'd0;
`endif
        end else begin
            case (state)
                START: begin
                    if (increment_ins_count) begin
                        pending <= 1'b1;
                    end
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end

                FETCH: begin
                    if (increment_ins_count) begin
                        pending <= 1'b1;
                    end
                    if (mem_ack) begin
                        instruction <= mem_rdata;
                        ins_valid   <= 1'b1;
                        state       <= READY;
                        mem_req     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
                        timeout_count <= 8'd0;
                    end else if (timeout_count == TIMEOUT_LAST) begin
                        state         <= ERROR;
                        mem_req       <= 1'b0;
                        fetch_error   <= 1'b1;
                        timeout_count <= 8'd0;
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
`endif
                    end
                end

                READY: begin
                    if (increment_ins_count) begin
                        pending <= 1'b1;
                    end
                    if (ins_accept) begin
                        ins_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                IDLE: begin
                    // A branch overrides both a fresh and a deferred increment.
                    if (branch_taken) begin
                        pc      <= branch_target;
                        pending <= 1'b0;
                        state   <= FETCH;
                        mem_req <= 1'b1;
                    end else if (increment_ins_count || pending) begin
                        pc      <= pc + 16'd1;
                        pending <= 1'b0;
                        state   <= FETCH;
                        mem_req <= 1'b1;
                    end
                end

                ERROR: begin
                    state   <= ERROR;
                    mem_req <= 1'b0;
                end

                default: begin
                    state   <= START;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Inputs are driven and outputs sampled on the falling clock edge.
// Build with FETCH_TIMEOUT_EN defined to exercise the timeout path.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        increment_ins_count;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        ins_valid;
    logic        ins_accept;
    logic [15:0] pc;
    logic        fetch_error;

    int total;
    int bad;

    fetch_unit #(
        .RESET_PC       (16'h0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .increment_ins_count (increment_ins_count),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .instruction         (instruction),
        .ins_valid           (ins_valid),
        .ins_accept          (ins_accept),
        .pc                  (pc),
        .fetch_error         (fetch_error)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    // From a FETCH cycle: ack one word, then let the decoder accept it,
    // leaving the DUT in IDLE.
    task automatic finish_fetch(input logic [15:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack    = 1'b0;
        ins_accept = 1'b1;
        step();
        ins_accept = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        increment_ins_count = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        ins_accept = 1'b0;
        step();
        step();
        total++;
        if (pc !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", pc); end
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        total++;
        if (ins_valid !== 1'b0 || instruction !== 16'h0000) begin
            bad++; $display("FAIL reset_ins got=%b/%h want=0/0000", ins_valid, instruction);
        end
        total++;
        if (fetch_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", fetch_error); end
        reset = 1'b0;
        step();
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            bad++; $display("FAIL first_fetch got=%b/%h want=1/0000", mem_req, mem_addr);
        end
    endtask

    task automatic test_first_fetch();
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        total++;
        if (instruction !== 16'h1234 || ins_valid !== 1'b1 || mem_req !== 1'b0) begin
            bad++; $display("FAIL capture got=%h/%b/%b want=1234/1/0", instruction, ins_valid, mem_req);
        end
        step();
        total++;
        if (ins_valid !== 1'b1 || instruction !== 16'h1234) begin
            bad++; $display("FAIL ready_hold got=%b/%h want=1/1234", ins_valid, instruction);
        end
        ins_accept = 1'b1;
        step();
        ins_accept = 1'b0;
        total++;
        if (ins_valid !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL accept got=%b/%b want=0/0", ins_valid, mem_req);
        end
        step();
        step();
        total++;
        if (pc !== 16'h0000 || mem_req !== 1'b0) begin
            bad++; $display("FAIL idle_hold got=%h/%b want=0000/0", pc, mem_req);
        end
    endtask

    task automatic test_wrap();
        branch_taken  = 1'b1;
        branch_target = 16'hFFFF;
        step();
        branch_taken = 1'b0;
        total++;
        if (pc !== 16'hFFFF || mem_req !== 1'b1 || mem_addr !== 16'hFFFF) begin
            bad++; $display("FAIL branch_ffff got=%h/%b/%h want=ffff/1/ffff", pc, mem_req, mem_addr);
        end
        finish_fetch(16'hABCD);
        increment_ins_count = 1'b1;
        step();
        increment_ins_count = 1'b0;
        total++;
        if (pc !== 16'h0000 || mem_req !== 1'b1) begin
            bad++; $display("FAIL wrap got=%h/%b want=0000/1", pc, mem_req);
        end
        finish_fetch(16'h0001);
    endtask

    task automatic test_branch_priority();
        branch_taken        = 1'b1;
        branch_target       = 16'h0040;
        increment_ins_count = 1'b1;
        step();
        branch_taken        = 1'b0;
        increment_ins_count = 1'b0;
        total++;
        if (pc !== 16'h0040 || mem_req !== 1'b1) begin
            bad++; $display("FAIL branch_prio got=%h/%b want=0040/1", pc, mem_req);
        end
        finish_fetch(16'h5555);
        step();
        step();
        total++;
        if (pc !== 16'h0040 || mem_req !== 1'b0) begin
            bad++; $display("FAIL no_late_inc got=%h/%b want=0040/0", pc, mem_req);
        end
    endtask

    task automatic test_pending();
        increment_ins_count = 1'b1;
        step();
        increment_ins_count = 1'b0;
        // Branch outside IDLE must be ignored.
        branch_taken  = 1'b1;
        branch_target = 16'h1234;
        step();
        branch_taken = 1'b0;
        total++;
        if (pc !== 16'h0041 || mem_req !== 1'b1) begin
            bad++; $display("FAIL branch_in_fetch got=%h/%b want=0041/1", pc, mem_req);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        step();
        mem_ack = 1'b0;
        increment_ins_count = 1'b1;
        step();
        step();
        increment_ins_count = 1'b0;
        ins_accept = 1'b1;
        step();
        ins_accept = 1'b0;
        total++;
        if (pc !== 16'h0041 || mem_req !== 1'b0 || ins_valid !== 1'b0) begin
            bad++; $display("FAIL pend_idle got=%h/%b/%b want=0041/0/0", pc, mem_req, ins_valid);
        end
        step();
        total++;
        if (pc !== 16'h0042 || mem_req !== 1'b1) begin
            bad++; $display("FAIL pend_inc got=%h/%b want=0042/1", pc, mem_req);
        end
        finish_fetch(16'h8888);
        step();
        step();
        total++;
        if (pc !== 16'h0042 || mem_req !== 1'b0) begin
            bad++; $display("FAIL pend_once got=%h/%b want=0042/0", pc, mem_req);
        end
        // Pending increment loses to a branch in the IDLE cycle that consumes it.
        increment_ins_count = 1'b1;
        step();
        increment_ins_count = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        increment_ins_count = 1'b1;
        ins_accept = 1'b1;
        step();
        increment_ins_count = 1'b0;
        ins_accept = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0100;
        step();
        branch_taken = 1'b0;
        total++;
        if (pc !== 16'h0100 || mem_req !== 1'b1) begin
            bad++; $display("FAIL pend_branch got=%h/%b want=0100/1", pc, mem_req);
        end
        finish_fetch(16'h9999);
        step();
        step();
        total++;
        if (pc !== 16'h0100 || mem_req !== 1'b0) begin
            bad++; $display("FAIL pend_cleared got=%h/%b want=0100/0", pc, mem_req);
        end
    endtask

    task automatic test_fetch_wait();
        increment_ins_count = 1'b1;
        step();
        increment_ins_count = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        step();
        step();
        step();
        total++;
        if (mem_req !== 1'b1 || fetch_error !== 1'b0) begin
            bad++; $display("FAIL pre_timeout got=%b/%b want=1/0", mem_req, fetch_error);
        end
        step();
        total++;
        if (mem_req !== 1'b0 || fetch_error !== 1'b1) begin
            bad++; $display("FAIL timeout got=%b/%b want=0/1", mem_req, fetch_error);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        increment_ins_count = 1'b1;
        step();
        step();
        step();
        mem_ack = 1'b0;
        increment_ins_count = 1'b0;
        total++;
        if (mem_req !== 1'b0 || fetch_error !== 1'b1 || ins_valid !== 1'b0) begin
            bad++; $display("FAIL error_sticky got=%b/%b/%b want=0/1/0", mem_req, fetch_error, ins_valid);
        end
`else
        for (int i = 0; i < 20; i++) begin
            step();
        end
        total++;
        if (mem_req !== 1'b1 || fetch_error !== 1'b0 || pc !== 16'h0101) begin
            bad++; $display("FAIL long_wait got=%b/%b/%h want=1/0/0101", mem_req, fetch_error, pc);
        end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        finish_fetch(16'h4321);
        increment_ins_count = 1'b1;
        step();
        increment_ins_count = 1'b0;
        total++;
        if (pc !== 16'h0001 || mem_req !== 1'b1) begin
            bad++; $display("FAIL pre_reset got=%h/%b want=0001/1", pc, mem_req);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b0 || pc !== 16'h0000 || ins_valid !== 1'b0 || fetch_error !== 1'b0) begin
            bad++; $display("FAIL async_reset got=%b/%h/%b/%b want=0/0000/0/0", mem_req, pc, ins_valid, fetch_error);
        end
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        reset = 1'b0;
        step();
        total++;
        if (ins_valid !== 1'b0 || instruction !== 16'h0000 || mem_req !== 1'b1) begin
            bad++; $display("FAIL late_ack got=%b/%h/%b want=0/0000/1", ins_valid, instruction, mem_req);
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_first_fetch();
        test_wrap();
        test_branch_priority();
        test_pending();
        test_fetch_wait();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
